// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one 256x32 single-port RAM between fetch (IF) and load/store (LS).
// Latency: grant and RAM drive are combinational in the request cycle; read data returns one cycle later.
// Backpressure: a losing requester holds req until gnt. RAM_ARB_LS_PRIO_EN selects fixed LS priority.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ram_rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wr_en,
    input  logic [DATA_W-1:0] ram_q,
    output logic [CNT_W-1:0]  contention_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              both_req;
    logic              ls_win;
    logic              if_own_q, if_own_d;
    logic              ls_own_q, ls_own_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign both_req = if_req & ls_req;
    assign ram_rst  = ~rst;

`ifdef RAM_ARB_LS_PRIO_EN
    assign ls_win = 1'b1;
`else
    // ptr_ls_q names the port that wins the next contended cycle.
    logic ptr_ls_q, ptr_ls_d;

    assign ls_win   = ptr_ls_q;
    assign ptr_ls_d = both_req ? ~ptr_ls_q : ptr_ls_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_ls_q <= 1'b1;
        end else begin
            ptr_ls_q <= ptr_ls_d;
        end
    end
`endif

    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (rst) begin
            if (ls_req && (!if_req || ls_win)) begin
                ls_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Address and data hold their last granted values on idle cycles.
    always_comb begin
        ram_addr  = addr_q;
        ram_data  = data_q;
        ram_wr_en = 1'b0;
        if (!rst) begin
            ram_addr = '0;
            ram_data = '0;
        end else if (ls_gnt) begin
            ram_addr  = ls_addr;
            ram_data  = ls_wdata;
            ram_wr_en = ls_we;
        end else if (if_gnt) begin
            ram_addr = if_addr;
        end
    end

    assign if_own_d = if_gnt;
    assign ls_own_d = ls_gnt & ~ls_we;
    assign cnt_d    = (both_req && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if_own_q <= 1'b0;
            ls_own_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            if_own_q <= if_own_d;
            ls_own_q <= ls_own_d;
            addr_q   <= ram_addr;
            data_q   <= ram_data;
            cnt_q    <= cnt_d;
        end
    end

    assign if_rvalid      = rst & if_own_q;
    assign ls_rvalid      = rst & ls_own_q;
    assign if_rdata       = ram_q;
    assign ls_rdata       = ram_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle-latency RAM; 3-bit counter to reach saturation.
module tb_ram_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req, ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt, ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ram_rst;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_q;
    logic [CNT_W-1:0]  contention_cnt;

    logic [DATA_W-1:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ram_rst(ram_rst), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_wr_en(ram_wr_en), .ram_q(ram_q), .contention_cnt(contention_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the rising edge. Check point: the following falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic exp_ls_win;
        logic prev_ls_win;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h30] = 32'h0BAD0030;
        mem[8'h31] = 32'hA5A50031;

        rst = 1'b0; if_req = 1'b1; if_addr = 8'h30;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h31; ls_wdata = 32'h0;

        // Reset held with both requests high.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("rst_if_gnt", 32'(if_gnt), 32'd0);
            check("rst_ls_gnt", 32'(ls_gnt), 32'd0);
            check("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
            check("rst_ram_rst", 32'(ram_rst), 32'd1);
            check("rst_cnt", 32'(contention_cnt), 32'd0);
            check("rst_ram_addr", 32'(ram_addr), 32'd0);
            check("rst_wr_en", 32'(ram_wr_en), 32'd0);
        end

        next_cycle(); rst = 1'b1;
        sample();
        check("rel_ls_gnt", 32'(ls_gnt), 32'd1);
        check("rel_if_gnt", 32'(if_gnt), 32'd0);
        check("rel_ram_addr", 32'(ram_addr), 32'h31);
        check("rel_ram_rst", 32'(ram_rst), 32'd0);

        next_cycle(); ls_req = 1'b0;
        sample();
        check("rel2_if_gnt", 32'(if_gnt), 32'd1);
        check("rel2_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("rel2_ls_rdata", ls_rdata, 32'hA5A50031);
        check("rel2_cnt", 32'(contention_cnt), 32'd1);

        next_cycle(); if_req = 1'b0;
        sample();
        check("rel3_if_rvalid", 32'(if_rvalid), 32'd1);
        check("rel3_if_rdata", if_rdata, 32'h0BAD0030);
        check("rel3_ls_rvalid", 32'(ls_rvalid), 32'd0);

        // Single IF read.
        next_cycle(); if_req = 1'b1; if_addr = 8'h10;
        sample();
        check("ifrd_gnt", 32'(if_gnt), 32'd1);
        check("ifrd_addr", 32'(ram_addr), 32'h10);
        check("ifrd_wr_en", 32'(ram_wr_en), 32'd0);
        next_cycle(); if_req = 1'b0;
        sample();
        check("ifrd_rvalid", 32'(if_rvalid), 32'd1);
        check("ifrd_rdata", if_rdata, 32'hDEADBEEF);
        check("ifrd_ls_rvalid", 32'(ls_rvalid), 32'd0);
        check("ifrd_gnt_idle", 32'(if_gnt), 32'd0);
        check("ifrd_addr_hold", 32'(ram_addr), 32'h10);

        // Store then load.
        next_cycle(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h20; ls_wdata = 32'h12345678;
        sample();
        check("st_gnt", 32'(ls_gnt), 32'd1);
        check("st_wr_en", 32'(ram_wr_en), 32'd1);
        check("st_addr", 32'(ram_addr), 32'h20);
        check("st_data", ram_data, 32'h12345678);
        next_cycle(); ls_we = 1'b0;
        sample();
        check("ld_gnt", 32'(ls_gnt), 32'd1);
        check("ld_wr_en", 32'(ram_wr_en), 32'd0);
        check("st_no_rvalid", 32'(ls_rvalid), 32'd0);
        next_cycle(); ls_req = 1'b0;
        sample();
        check("ld_rvalid", 32'(ls_rvalid), 32'd1);
        check("ld_rdata", ls_rdata, 32'h12345678);
        check("ld_if_rvalid", 32'(if_rvalid), 32'd0);
        check("ld_wr_en_idle", 32'(ram_wr_en), 32'd0);

        // Fresh reset, then four contended cycles.
        next_cycle(); rst = 1'b0;
        next_cycle(); rst = 1'b1;
        if_req = 1'b1; if_addr = 8'h10; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h20;
        prev_ls_win = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_LS_PRIO_EN
            exp_ls_win = 1'b1;
`else
            exp_ls_win = (i % 2 == 0);
`endif
            sample();
            check($sformatf("cont%0d_ls_gnt", i), 32'(ls_gnt), 32'(exp_ls_win));
            check($sformatf("cont%0d_if_gnt", i), 32'(if_gnt), 32'(!exp_ls_win));
            if (i > 0) begin
                check($sformatf("cont%0d_ls_rvalid", i), 32'(ls_rvalid), 32'(prev_ls_win));
                check($sformatf("cont%0d_if_rvalid", i), 32'(if_rvalid), 32'(!prev_ls_win));
                check($sformatf("cont%0d_rdata", i), ram_q,
                      prev_ls_win ? 32'h12345678 : 32'hDEADBEEF);
            end
            prev_ls_win = exp_ls_win;
            next_cycle();
        end
        ls_req = 1'b0;
        sample();
        check("cont_if_after_ls_drop", 32'(if_gnt), 32'd1);
        check("cont_last_ls_rvalid", 32'(ls_rvalid), 32'(prev_ls_win));
        check("cont_last_if_rvalid", 32'(if_rvalid), 32'(!prev_ls_win));
        check("cont_cnt", 32'(contention_cnt), 32'd4);
        next_cycle(); if_req = 1'b0;
        sample();
        check("cont_tail_if_rvalid", 32'(if_rvalid), 32'd1);
        check("cont_tail_if_rdata", if_rdata, 32'hDEADBEEF);
        check("cont_cnt_stable", 32'(contention_cnt), 32'd4);

        // Read granted, then reset in the return cycle: the return is dropped.
        next_cycle(); if_req = 1'b1; if_addr = 8'h10;
        sample();
        check("mid_if_gnt", 32'(if_gnt), 32'd1);
        next_cycle(); if_req = 1'b0; rst = 1'b0;
        sample();
        check("mid_rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("mid_rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
        next_cycle(); rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            check($sformatf("mid_post%0d_rvalid", i), 32'({if_rvalid, ls_rvalid}), 32'd0);
            next_cycle();
        end

        // Counter saturates at all-ones (3-bit build) instead of wrapping.
        if_req = 1'b1; ls_req = 1'b1;
        for (int i = 0; i < 9; i++) next_cycle();
        if_req = 1'b0; ls_req = 1'b0;
        sample();
        check("cnt_saturate", 32'(contention_cnt), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
